// File: rtl/serial_frame_rx_if.sv
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : Serial line, parallel valid/ready word and status signals of
//            serial_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_frame_rx_if #(
    parameter int NBITS = 4
) ();
    logic             si;
    logic [NBITS-1:0] dout;
    logic             dvalid;
    logic             dready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    // master: the receiver; slave: line driver plus word consumer
    modport master (
        input  si,
        input  dready,
        output dout,
        output dvalid,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        output si,
        output dready,
        input  dout,
        input  dvalid,
        input  busy,
        input  frame_err,
        input  overrun
    );
endinterface

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : One-sample-per-clock serial frame receiver (start, NBITS data
//            LSB first, optional even parity, stop) with a valid/ready output.
//            Optional feature macro: PARITY_EN (adds the parity bit/state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_rx #(
    parameter int NBITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_frame_rx_if.master  bus
);

    localparam int                 c_CNT_W = $clog2(NBITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NBITS - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STOP   = 2'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NBITS-1:0]   r_shift;
    logic [NBITS-1:0]   w_shift_next;
    logic [NBITS-1:0]   r_dout;
    logic               r_dvalid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_stop;
    logic               w_par_ok;
    logic               w_good;
    logic               w_load;
`ifdef PARITY_EN
    logic               r_par;
`endif

    // New bits enter at the MSB so that after NBITS shifts bit 0 is the first one sent
    generate
        if (NBITS == 1) begin : g_shift_one
            assign w_shift_next = bus.si;
        end else begin : g_shift_multi
            assign w_shift_next = {bus.si, r_shift[NBITS-1:1]};
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.si) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
`ifdef PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: w_next = S_STOP;
`endif
            S_STOP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stop   = (r_state == S_STOP);
`ifdef PARITY_EN
        w_par_ok = ~(^r_shift ^ r_par);
`else
        w_par_ok = 1'b1;
`endif
        w_good   = w_stop && bus.si && w_par_ok;
        // Accepting the held word on the same edge frees the register for the new one
        w_load   = w_good && (!r_dvalid || bus.dready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_dvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_stop && !w_good;
            r_overrun   <= w_good && !w_load;

            if (r_state == S_IDLE && !bus.si) begin
                r_cnt <= '0;
            end else if (r_state == S_DATA) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= w_shift_next;
            end

`ifdef PARITY_EN
            if (r_state == S_PARITY) begin
                r_par <= bus.si;
            end
`endif

            if (w_load) begin
                r_dout   <= r_shift;
                r_dvalid <= 1'b1;
            end else if (r_dvalid && bus.dready) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.dvalid    = r_dvalid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire
